a51_stream_decrypt: RTL and testbench
=====================================

# a51_stream_decrypt

Byte-stream A5/1 decryptor. It loads a 64-bit session key and a 22-bit frame number, runs the standard A5/1 key/frame mixing and 100-cycle warm-up, then XORs incoming ciphertext bytes with the generated keystream. It returns plaintext bytes over a valid/ready interface. The block is the receive-side counterpart of the bit-serial A5/1 encryptor: the same LFSR taps and majority clocking, but a full keying sequence and byte-level flow control.

## Interface
- LEN_W, default 16, width of the message-length input in bytes.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- key  in  64  session key; key[0] is loaded first. Sampled on start.
- frame  in  22  frame number; frame[0] is loaded first. Sampled on start.
- len  in  LEN_W  number of ciphertext bytes to decrypt. Sampled on start.
- ct_valid  in  1  ciphertext byte valid.
- ct_ready  out  1  block accepts a ciphertext byte.
- ct_data  in  8  ciphertext byte.
- pt_valid  out  1  plaintext byte valid.
- pt_ready  in  1  consumer accepts the plaintext byte.
- pt_data  out  8  plaintext byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the message is complete.

## Operation
- Registers: R1 19 b, R2 22 b, R3 23 b.
- Clock step: R <= {R[n-2:0], parity(R & taps)}.
  - Taps: R1 {13,16,17,18}, R2 {20,21}, R3 {7,20,21,22}.
- Majority step:
  - maj = majority(R1[8], R2[10], R3[10]).
  - Each register steps only if its clock bit equals maj.
- Keystream bit = R1[18] ^ R2[21] ^ R3[22], taken from the state after the step in that cycle.
- FSM states: IDLE, KEYLD, FRMLD, WARM, WAIT_CT, GEN, OUT, FIN.
- IDLE:
  - On start with len≠0: zero R1–R3, latch key/frame/len, go to KEYLD.
  - On start with len=0: go to FIN.
- KEYLD (64 cycles): all three registers step unconditionally; then key bit i is XORed into bit 0 of each register.
- FRMLD (22 cycles): same as KEYLD, using frame bits.
- WARM (100 cycles): majority steps; output is discarded.
- WAIT_CT:
  - ct_ready=1.
  - On ct_valid&ct_ready: latch ct_data, go to GEN.
- GEN (8 cycles):
  - One majority step per cycle.
  - The first keystream bit is XORed into ct bit 7; the last into bit 0 (MSB first).
- OUT:
  - pt_valid=1; pt_data is stable.
  - On pt_ready: decrement the remaining count. Go to WAIT_CT if the count is non-zero, otherwise FIN.
- FIN: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored; key/frame/len changes after start are ignored.

## Timing
- Reset values: ct_ready=0, pt_valid=0, pt_data=0, busy=0, done=0. State=IDLE, registers=0.
- Start accepted in cycle N:
  - KEYLD runs N+1..N+64.
  - FRMLD runs N+65..N+86.
  - WARM runs N+87..N+186.
  - ct_ready is first high at N+187.
- Ciphertext handshake in cycle M: GEN runs M+1..M+8; pt_valid is first high at M+9.
- Maximum throughput: 1 byte per 10 cycles (back-to-back valid/ready).
- ct_ready is low in GEN, OUT and FIN. No keystream advance occurs while waiting in WAIT_CT or OUT.
- pt_data/pt_valid hold unchanged until pt_ready is sampled high.
- Last-byte handshake in cycle K: done at K+1; busy low at K+2.
- len=0: done at N+1, no keying.
- Reset mid-operation: immediate return to reset values. A pending byte is dropped; no done pulse is produced.

## Structure
- Package a51_pkg holds:
  - Register lengths 19/22/23.
  - Tap masks 19'h72000, 22'h300000, 23'h700080.
  - Clock-bit indices 8/10/10.
  - Load counts 64/22/100.
  - FSM state enum.
- Sub-module a51_keystream_gen holds:
  - R1–R3.
  - Inputs: load-mode step, majority step, load bit.
  - Output: keystream bit.
- The top level holds the FSM, the shared cycle/bit counter, the byte shift register and the length counter.

## Test plan
- Known vector: key=64'hEFCDAB8967452312, frame=22'h134, len=2, ct=8'h00,8'h00 -> pt=8'h53,8'h4E; done once; ct_ready first high 187 cycles after start.
- Round trip: same key/frame, ct=8'h53,8'h4E -> pt=8'h00,8'h00.
- Backpressure: pt_ready held low 20 cycles -> pt_data stable; next byte still decrypts to its correct vector value.
- Idle source: 50-cycle gap before ct_valid -> keystream unchanged; pt matches the gap-free run.
- Control corners:
  - len=0 -> done 1 cycle after start.
  - start during WARM -> ignored.
- Reset asserted at GEN cycle 4 -> all outputs at reset values. A fresh start reproduces the known vector.

Source files
------------

// File: rtl/a51_pkg.sv
// Shared constants, state encoding and helpers for the A5/1 stream decryptor.
// LFSR geometry follows the GSM A5/1 definition: three registers with majority clocking.
package a51_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    localparam int KEY_CYCLES   = 64;
    localparam int FRAME_CYCLES = 22;
    localparam int WARM_CYCLES  = 100;
    localparam int BYTE_CYCLES  = 8;

    // Wide enough for the longest phase (warm-up).
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        KEYLD,
        FRMLD,
        WARM,
        WAIT_CT,
        GEN,
        OUT,
        FIN
    } a51_state_e;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_keystream_gen.sv
// A5/1 LFSR core: unconditional stepping with bit injection during keying,
// majority-clocked stepping during warm-up and keystream generation.
module a51_keystream_gen
    import a51_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load_step,
    input  logic maj_step,
    input  logic load_bit,
    output logic ks_bit
);

    logic [R1_LEN-1:0] r1, r1_nxt, r1_stp;
    logic [R2_LEN-1:0] r2, r2_nxt, r2_stp;
    logic [R3_LEN-1:0] r3, r3_nxt, r3_stp;
    logic              maj;

    assign r1_stp = {r1[R1_LEN-2:0], ^(r1 & R1_TAPS)};
    assign r2_stp = {r2[R2_LEN-2:0], ^(r2 & R2_TAPS)};
    assign r3_stp = {r3[R3_LEN-2:0], ^(r3 & R3_TAPS)};
    assign maj    = majority(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);

    always_comb begin
        r1_nxt = r1;
        r2_nxt = r2;
        r3_nxt = r3;
        if (load_step) begin
            r1_nxt = {r1_stp[R1_LEN-1:1], r1_stp[0] ^ load_bit};
            r2_nxt = {r2_stp[R2_LEN-1:1], r2_stp[0] ^ load_bit};
            r3_nxt = {r3_stp[R3_LEN-1:1], r3_stp[0] ^ load_bit};
        end else if (maj_step) begin
            if (r1[R1_CLK] == maj) r1_nxt = r1_stp;
            if (r2[R2_CLK] == maj) r2_nxt = r2_stp;
            if (r3[R3_CLK] == maj) r3_nxt = r3_stp;
        end
    end

    // Keystream is taken from the post-step state so it lines up with this cycle's shift.
    assign ks_bit = r1_nxt[R1_LEN-1] ^ r2_nxt[R2_LEN-1] ^ r3_nxt[R3_LEN-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else if (clear) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else begin
            r1 <= r1_nxt;
            r2 <= r2_nxt;
            r3 <= r3_nxt;
        end
    end

endmodule

// File: rtl/a51_stream_decrypt.sv
// Byte-stream A5/1 decryptor: keys the LFSRs from key/frame, warms up, then
// XORs each accepted ciphertext byte (MSB first) with eight keystream bits.
module a51_stream_decrypt
    import a51_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      key,
    input  logic [21:0]      frame,
    input  logic [LEN_W-1:0] len,
    input  logic             ct_valid,
    output logic             ct_ready,
    input  logic [7:0]       ct_data,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic [7:0]       pt_data,
    output logic             busy,
    output logic             done
);

    a51_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             counting;
    logic [63:0]      key_q;
    logic [21:0]      frame_q;
    logic [LEN_W-1:0] remain;
    logic [7:0]       byte_sr;
    logic             clear, load_step, maj_step, load_bit, ks_bit;
    logic             ct_fire;

    assign clear     = (state == IDLE) && start && (len != '0);
    assign load_step = (state == KEYLD) || (state == FRMLD);
    assign maj_step  = (state == WARM) || (state == GEN);
    assign load_bit  = (state == KEYLD) ? key_q[cnt[5:0]] : frame_q[cnt[4:0]];
    assign counting  = load_step || maj_step;
    assign ct_fire   = (state == WAIT_CT) && ct_valid;

    always_comb begin
        cnt_last = 1'b0;
        case (state)
            KEYLD:   cnt_last = (cnt == CNT_W'(KEY_CYCLES - 1));
            FRMLD:   cnt_last = (cnt == CNT_W'(FRAME_CYCLES - 1));
            WARM:    cnt_last = (cnt == CNT_W'(WARM_CYCLES - 1));
            GEN:     cnt_last = (cnt == CNT_W'(BYTE_CYCLES - 1));
            default: cnt_last = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? FIN : KEYLD;
            end
            KEYLD:   if (cnt_last) state_nxt = FRMLD;
            FRMLD:   if (cnt_last) state_nxt = WARM;
            WARM:    if (cnt_last) state_nxt = WAIT_CT;
            WAIT_CT: if (ct_valid) state_nxt = GEN;
            GEN:     if (cnt_last) state_nxt = OUT;
            OUT: begin
                if (pt_ready) state_nxt = (remain == LEN_W'(1)) ? FIN : WAIT_CT;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ct_ready = (state == WAIT_CT);
    assign pt_valid = (state == OUT);
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign pt_data  = byte_sr;

    a51_keystream_gen u_ksg (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load_step (load_step),
        .maj_step  (maj_step),
        .load_bit  (load_bit),
        .ks_bit    (ks_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            remain  <= '0;
            byte_sr <= '0;
        end else begin
            state <= state_nxt;
            // The counter restarts on every phase change so each phase counts from zero.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (counting) begin
                cnt <= cnt + CNT_W'(1);
            end
            if ((state == IDLE) && start) begin
                remain <= len;
            end else if ((state == OUT) && pt_ready) begin
                remain <= remain - LEN_W'(1);
            end
            if (ct_fire) begin
                byte_sr <= ct_data;
            end else if (state == GEN) begin
                byte_sr <= {byte_sr[6:0], byte_sr[7] ^ ks_bit};
            end
        end
    end

    // Session parameters are data only; they are captured once per start.
    always_ff @(posedge clk) begin
        if (clear) begin
            key_q   <= key;
            frame_q <= frame;
        end
    end

endmodule

// File: tb/tb_a51_stream_decrypt.sv
// Directed bench for a51_stream_decrypt against the published A5/1 reference vector.
module tb_a51_stream_decrypt;

    localparam int          LEN_W = 16;
    localparam logic [63:0] KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0] FRAME = 22'h134;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [63:0]      key;
    logic [21:0]      frame;
    logic [LEN_W-1:0] len;
    logic             ct_valid;
    logic             ct_ready;
    logic [7:0]       ct_data;
    logic             pt_valid;
    logic             pt_ready;
    logic [7:0]       pt_data;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    a51_stream_decrypt #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .frame    (frame),
        .len      (len),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ct_ready"}, ct_ready, 0);
        check({tag, "_pt_valid"}, pt_valid, 0);
        check({tag, "_pt_data"}, pt_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Called at a negedge; returns at the negedge where ct_ready first rises.
    task automatic open_session(input logic [63:0] k, input logic [21:0] f,
                                input logic [LEN_W-1:0] n, input bit poke, input string tag);
        int cyc;
        key = k; frame = f; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy_start"}, busy, 1);
        while (!ct_ready && cyc < 400) begin
            if (poke && cyc == 120) begin
                start = 1'b1; key = ~k; frame = ~f; len = '0;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check({tag, "_ct_ready_latency"}, cyc, 187);
    endtask

    task automatic xfer(input logic [7:0] c, input int gap, input int hold, input bit last,
                        input logic [7:0] exp_pt, input string tag);
        int   cyc;
        logic [7:0] held;
        bit   stable;
        cyc = 0;
        while (!ct_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ct_ready"}, ct_ready, 1);
        repeat (gap) @(negedge clk);
        ct_valid = 1'b1; ct_data = c;
        @(negedge clk);
        ct_valid = 1'b0; ct_data = 8'h00;
        cyc = 1;
        check({tag, "_ct_ready_gen"}, ct_ready, 0);
        while (!pt_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_pt_latency"}, cyc, 9);
        held = pt_data;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (pt_data !== held || pt_valid !== 1'b1) stable = 1'b0;
        end
        if (hold > 0) check({tag, "_pt_stable"}, stable, 1);
        check({tag, "_pt_data"}, pt_data, exp_pt);
        pt_ready = 1'b1;
        @(negedge clk);
        pt_ready = 1'b0;
        check({tag, "_done"}, done, last);
        check({tag, "_pt_valid_drop"}, pt_valid, 0);
        if (last) begin
            @(negedge clk);
            check({tag, "_done_end"}, done, 0);
            check({tag, "_busy_end"}, busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key = '0; frame = '0; len = '0;
        ct_valid = 1'b0; ct_data = 8'h00; pt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Reference vector: all-zero ciphertext yields the raw keystream.
        open_session(KEY, FRAME, 16'd2, 1'b0, "kv");
        xfer(8'h00, 0, 0, 1'b0, 8'h53, "kv0");
        xfer(8'h00, 0, 0, 1'b1, 8'h4E, "kv1");

        open_session(KEY, FRAME, 16'd2, 1'b0, "rt");
        xfer(8'h53, 0, 0, 1'b0, 8'h00, "rt0");
        xfer(8'h4E, 0, 0, 1'b1, 8'h00, "rt1");

        open_session(KEY, FRAME, 16'd2, 1'b0, "bp");
        xfer(8'h00, 0, 20, 1'b0, 8'h53, "bp0");
        xfer(8'h00, 0, 0, 1'b1, 8'h4E, "bp1");

        open_session(KEY, FRAME, 16'd2, 1'b0, "gap");
        xfer(8'h00, 50, 0, 1'b0, 8'h53, "gap0");
        xfer(8'h00, 0, 0, 1'b1, 8'h4E, "gap1");

        // Zero-length message finishes without keying.
        len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 1);
        check("len0_ct_ready", ct_ready, 0);
        @(negedge clk);
        check("len0_done_end", done, 0);
        check("len0_busy_end", busy, 0);

        open_session(KEY, FRAME, 16'd2, 1'b1, "poke");
        xfer(8'h00, 0, 0, 1'b0, 8'h53, "poke0");
        xfer(8'h00, 0, 0, 1'b1, 8'h4E, "poke1");

        // Reset lands in the fourth GEN cycle of a byte.
        open_session(KEY, FRAME, 16'd2, 1'b0, "rst");
        ct_valid = 1'b1; ct_data = 8'hFF;
        @(negedge clk);
        ct_valid = 1'b0; ct_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        repeat (3) @(negedge clk);
        check("rst_no_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_after");
        open_session(KEY, FRAME, 16'd2, 1'b0, "fresh");
        xfer(8'h00, 0, 0, 1'b0, 8'h53, "fresh0");
        xfer(8'h00, 0, 0, 1'b1, 8'h4E, "fresh1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
